// File: rtl/ps_seq_pkg.sv
// Shared constants for the program-sequencer stack controller:
// status-flag bit positions and the field layout of a loop-stack entry.
package ps_seq_pkg;

    // Bit positions inside ps_stcky
    localparam int PC_EMPTY = 0;
    localparam int PC_FULL  = 1;
    localparam int PC_OVF   = 2;
    localparam int PC_UNF   = 3;
    localparam int LP_EMPTY = 4;
    localparam int LP_FULL  = 5;
    localparam int LP_OVF   = 6;
    localparam int LP_UNF   = 7;

    // A loop entry is packed as {sadd, eadd, cnt}: count in the low bits,
    // end address above it, start address on top.
    localparam int LP_CNT_LSB = 0;

    function automatic int lp_eadd_lsb(input int cw);
        return LP_CNT_LSB + cw;
    endfunction

    function automatic int lp_sadd_lsb(input int aw, input int cw);
        return LP_CNT_LSB + cw + aw;
    endfunction

endpackage

// File: rtl/ps_lifo_stk.sv
// Generic LIFO used for both the PC stack and the loop stack.
// One action per cycle, priority: push+pop (replace top), pop, push, top write.
// The top entry is presented combinationally (0 when empty); ovf/unf are
// single-cycle pulses reporting a rejected push or pop.
module ps_lifo_stk #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_dt,
    input  logic                         wrt,
    input  logic [W-1:0]                 wrt_dt,
    output logic [W-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   pntr,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf
);

    localparam int PW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] top_idx;
    logic          do_push;
    logic          do_repl;
    logic          do_pop;
    logic          do_wrt;

    assign empty   = (pntr == '0);
    assign full    = (pntr == PW'(DEPTH));
    assign top_idx = pntr - PW'(1);

    // push+pop on an empty stack degrades to a plain push
    assign do_repl = push & pop & ~empty;
    assign do_push = push & (pop ? empty : ~full);
    assign do_pop  = pop & ~push & ~empty;
    assign do_wrt  = wrt & ~push & ~pop & ~empty;
    assign ovf     = push & ~pop & full;
    assign unf     = pop & ~push & empty;

    // Select the current top entry; an empty stack reads as zero
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!empty && PW'(i) == top_idx) begin
                top = mem[i];
            end
        end
    end

    // Pointer and entry storage update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pntr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                pntr <= pntr + PW'(1);
            end else if (do_pop) begin
                pntr <= pntr - PW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && PW'(i) == pntr) begin
                    mem[i] <= push_dt;
                end else if (do_repl && PW'(i) == top_idx) begin
                    mem[i] <= push_dt;
                end else if (do_wrt && PW'(i) == top_idx) begin
                    mem[i] <= wrt_dt;
                end
            end
        end
    end

endmodule

// File: rtl/ps_seq_stk_ctl.sv
// PC stack plus hardware DO-UNTIL loop stack for the program sequencer.
// Only the innermost (top) loop level is compared against the fetch address;
// a non-terminal hit redirects fetch to the loop start and decrements the
// count, a terminal hit falls through and retires the level.
module ps_seq_stk_ctl
    import ps_seq_pkg::*;
#(
    parameter int AW       = 16,
    parameter int CW       = 16,
    parameter int PC_DEPTH = 4,
    parameter int LP_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps_push,
    input  logic [AW-1:0]                   ps_push_dt,
    input  logic                            ps_pop,
    input  logic                            ps_stk_wrt,
    input  logic [AW-1:0]                   ps_stk_wrt_dt,
    input  logic                            ps_lp_start,
    input  logic [AW-1:0]                   ps_lp_sadd,
    input  logic [AW-1:0]                   ps_lp_eadd,
    input  logic [CW-1:0]                   ps_lp_cnt,
    input  logic                            ps_lp_abort,
    input  logic                            ps_fetch_en,
    input  logic [AW-1:0]                   ps_fetch_add,
    input  logic                            ps_stcky_clr,
    output logic [AW-1:0]                   ps_stk_top,
    output logic [$clog2(PC_DEPTH+1)-1:0]   ps_stk_pntr,
    output logic [$clog2(LP_DEPTH+1)-1:0]   ps_lp_pntr,
    output logic [CW-1:0]                   ps_lp_cnt_cur,
    output logic                            ps_lp_jmp,
    output logic [AW-1:0]                   ps_lp_jmp_add,
    output logic [7:0]                      ps_stcky
);

    localparam int LW       = 2*AW + CW;
    localparam int EADD_LSB = lp_eadd_lsb(CW);
    localparam int SADD_LSB = lp_sadd_lsb(AW, CW);

    logic          pc_full, pc_empty, pc_ovf, pc_unf;
    logic          lp_full, lp_empty, lp_ovf, lp_unf;
    logic [LW-1:0] lp_top;
    logic [LW-1:0] lp_push_dt;
    logic [LW-1:0] lp_wrt_dt;
    logic [AW-1:0] top_sadd;
    logic [AW-1:0] top_eadd;
    logic [CW-1:0] top_cnt;
    logic [CW-1:0] start_cnt;
    logic          lp_hit;
    logic          lp_last;
    logic          lp_pop;
    // {lp_unf, lp_ovf, pc_unf, pc_ovf}
    logic [3:0]    err_q;

    ps_lifo_stk #(.W(AW), .DEPTH(PC_DEPTH)) u_pc_stk (
        .clk     (clk),
        .rst     (rst),
        .push    (ps_push),
        .pop     (ps_pop),
        .push_dt (ps_push_dt),
        .wrt     (ps_stk_wrt),
        .wrt_dt  (ps_stk_wrt_dt),
        .top     (ps_stk_top),
        .pntr    (ps_stk_pntr),
        .full    (pc_full),
        .empty   (pc_empty),
        .ovf     (pc_ovf),
        .unf     (pc_unf)
    );

    assign top_cnt  = lp_top[LP_CNT_LSB +: CW];
    assign top_eadd = lp_top[EADD_LSB +: AW];
    assign top_sadd = lp_top[SADD_LSB +: AW];

    // A zero iteration count means a single pass
    assign start_cnt  = (ps_lp_cnt == '0) ? CW'(1) : ps_lp_cnt;
    assign lp_push_dt = {ps_lp_sadd, ps_lp_eadd, start_cnt};

    assign lp_hit    = ps_fetch_en & ~lp_empty & (ps_fetch_add == top_eadd);
    assign lp_last   = (top_cnt <= CW'(1));
    assign lp_pop    = ps_lp_abort | (lp_hit & lp_last);
    assign ps_lp_jmp = lp_hit & ~lp_last & ~ps_lp_abort;
    assign lp_wrt_dt = {top_sadd, top_eadd, top_cnt - CW'(1)};

    assign ps_lp_jmp_add = top_sadd;
    assign ps_lp_cnt_cur = top_cnt;

    // The count decrement rides on the top-write path, so a loop start or
    // pop in the same cycle takes precedence over it inside the LIFO.
    ps_lifo_stk #(.W(LW), .DEPTH(LP_DEPTH)) u_lp_stk (
        .clk     (clk),
        .rst     (rst),
        .push    (ps_lp_start),
        .pop     (lp_pop),
        .push_dt (lp_push_dt),
        .wrt     (ps_lp_jmp),
        .wrt_dt  (lp_wrt_dt),
        .top     (lp_top),
        .pntr    (ps_lp_pntr),
        .full    (lp_full),
        .empty   (lp_empty),
        .ovf     (lp_ovf),
        .unf     (lp_unf)
    );

    // Overflow/underflow stickies; a new event wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= (ps_stcky_clr ? 4'b0 : err_q) | {lp_unf, lp_ovf, pc_unf, pc_ovf};
        end
    end

    // Assemble the status word from occupancy flags and stickies
    always_comb begin
        ps_stcky           = '0;
        ps_stcky[PC_EMPTY] = pc_empty;
        ps_stcky[PC_FULL]  = pc_full;
        ps_stcky[PC_OVF]   = err_q[0];
        ps_stcky[PC_UNF]   = err_q[1];
        ps_stcky[LP_EMPTY] = lp_empty;
        ps_stcky[LP_FULL]  = lp_full;
        ps_stcky[LP_OVF]   = err_q[2];
        ps_stcky[LP_UNF]   = err_q[3];
    end

endmodule

// File: tb/tb_ps_seq_stk_ctl.sv
// Directed bench for ps_seq_stk_ctl with default parameters
// (AW=16, CW=16, PC_DEPTH=4, LP_DEPTH=2).
module tb_ps_seq_stk_ctl;

    logic        clk;
    logic        rst;
    logic        ps_push;
    logic [15:0] ps_push_dt;
    logic        ps_pop;
    logic        ps_stk_wrt;
    logic [15:0] ps_stk_wrt_dt;
    logic        ps_lp_start;
    logic [15:0] ps_lp_sadd;
    logic [15:0] ps_lp_eadd;
    logic [15:0] ps_lp_cnt;
    logic        ps_lp_abort;
    logic        ps_fetch_en;
    logic [15:0] ps_fetch_add;
    logic        ps_stcky_clr;
    logic [15:0] ps_stk_top;
    logic [2:0]  ps_stk_pntr;
    logic [1:0]  ps_lp_pntr;
    logic [15:0] ps_lp_cnt_cur;
    logic        ps_lp_jmp;
    logic [15:0] ps_lp_jmp_add;
    logic [7:0]  ps_stcky;

    ps_seq_stk_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .ps_push       (ps_push),
        .ps_push_dt    (ps_push_dt),
        .ps_pop        (ps_pop),
        .ps_stk_wrt    (ps_stk_wrt),
        .ps_stk_wrt_dt (ps_stk_wrt_dt),
        .ps_lp_start   (ps_lp_start),
        .ps_lp_sadd    (ps_lp_sadd),
        .ps_lp_eadd    (ps_lp_eadd),
        .ps_lp_cnt     (ps_lp_cnt),
        .ps_lp_abort   (ps_lp_abort),
        .ps_fetch_en   (ps_fetch_en),
        .ps_fetch_add  (ps_fetch_add),
        .ps_stcky_clr  (ps_stcky_clr),
        .ps_stk_top    (ps_stk_top),
        .ps_stk_pntr   (ps_stk_pntr),
        .ps_lp_pntr    (ps_lp_pntr),
        .ps_lp_cnt_cur (ps_lp_cnt_cur),
        .ps_lp_jmp     (ps_lp_jmp),
        .ps_lp_jmp_add (ps_lp_jmp_add),
        .ps_stcky      (ps_stcky)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_vec;
    int n_err;

    task automatic exp_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        ps_push = 1'b0; ps_push_dt = '0; ps_pop = 1'b0;
        ps_stk_wrt = 1'b0; ps_stk_wrt_dt = '0;
        ps_lp_start = 1'b0; ps_lp_sadd = '0; ps_lp_eadd = '0; ps_lp_cnt = '0;
        ps_lp_abort = 1'b0; ps_fetch_en = 1'b0; ps_fetch_add = '0;
        ps_stcky_clr = 1'b0;
    endtask

    // apply the currently driven inputs for one clock edge, then go idle
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic pc_push(input logic [15:0] d);
        ps_push = 1'b1; ps_push_dt = d;
        cyc();
    endtask

    task automatic lp_open(input logic [15:0] s, input logic [15:0] e, input logic [15:0] c);
        ps_lp_start = 1'b1; ps_lp_sadd = s; ps_lp_eadd = e; ps_lp_cnt = c;
        cyc();
    endtask

    // Fetch unit model: walks sequential addresses, follows redirects,
    // optionally opens an inner loop when open_at is fetched.
    int f_cnt, j_a, j_b, j_bad, w_cnt, timed_out;

    task automatic fetch_run(input logic [15:0] start_pc, input logic [15:0] exit_pc,
                             input logic [15:0] open_at, input logic [15:0] in_s,
                             input logic [15:0] in_e, input logic [15:0] in_c,
                             input logic [15:0] t_a, input logic [15:0] t_b,
                             input logic [15:0] watch);
        logic [15:0] pc;
        logic [15:0] nxt;
        int n;
        pc = start_pc;
        f_cnt = 0; j_a = 0; j_b = 0; j_bad = 0; w_cnt = 0; timed_out = 0; n = 0;
        while (pc != exit_pc && n < 500) begin
            ps_fetch_en = 1'b1;
            ps_fetch_add = pc;
            if (pc == open_at) begin
                ps_lp_start = 1'b1; ps_lp_sadd = in_s; ps_lp_eadd = in_e; ps_lp_cnt = in_c;
            end
            #1;
            f_cnt++;
            if (pc == watch) w_cnt++;
            if (ps_lp_jmp === 1'b1) begin
                if (ps_lp_jmp_add == t_a) j_a++;
                else if (ps_lp_jmp_add == t_b) j_b++;
                else j_bad++;
                nxt = ps_lp_jmp_add;
            end else begin
                nxt = pc + 16'd1;
            end
            cyc();
            pc = nxt;
            n++;
        end
        if (n >= 500) timed_out = 1;
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0] pv [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        idle();
        #1 rst = 1'b1;
        #2;
        exp_push(32'h0);  chk("rst_top", 32'(ps_stk_top));
        exp_push(32'h0);  chk("rst_pntr", 32'(ps_stk_pntr));
        exp_push(32'h0);  chk("rst_lp_pntr", 32'(ps_lp_pntr));
        exp_push(32'h11); chk("rst_stcky", 32'(ps_stcky));
        exp_push(32'h0);  chk("rst_jmp", 32'(ps_lp_jmp));
        exp_push(32'h0);  chk("rst_cnt_cur", 32'(ps_lp_cnt_cur));
        @(negedge clk);
        rst = 1'b0;

        // PC stack fill, overflow, drain
        pv[0] = 16'h0010; pv[1] = 16'h0020; pv[2] = 16'h0030; pv[3] = 16'h0040;
        exp_push(32'd4); exp_push(32'd1); exp_push(32'h40);
        for (int i = 0; i < 4; i++) pc_push(pv[i]);
        chk("fill_pntr", 32'(ps_stk_pntr));
        chk("fill_full", 32'(ps_stcky[1]));
        chk("fill_top", 32'(ps_stk_top));
        exp_push(32'd1); exp_push(32'h40); exp_push(32'd4);
        pc_push(16'h0050);
        chk("ovf_flag", 32'(ps_stcky[2]));
        chk("ovf_top", 32'(ps_stk_top));
        chk("ovf_pntr", 32'(ps_stk_pntr));
        for (int i = 3; i >= 0; i--) begin
            exp_push(32'(pv[i]));
            chk("pop_top", 32'(ps_stk_top));
            ps_pop = 1'b1;
            cyc();
        end
        exp_push(32'd0); exp_push(32'd1);
        chk("drain_pntr", 32'(ps_stk_pntr));
        chk("drain_empty", 32'(ps_stcky[0]));

        // Underflow, set-beats-clear, clear
        exp_push(32'd1); exp_push(32'd0);
        ps_pop = 1'b1; cyc();
        chk("unf_flag", 32'(ps_stcky[3]));
        chk("unf_pntr", 32'(ps_stk_pntr));
        exp_push(32'h19);
        ps_pop = 1'b1; ps_stcky_clr = 1'b1; cyc();
        chk("set_wins", 32'(ps_stcky));
        exp_push(32'h11);
        ps_stcky_clr = 1'b1; cyc();
        chk("clr", 32'(ps_stcky));

        // Push+pop replace, top write, write ignored under pop / when empty
        pc_push(16'h0010);
        pc_push(16'h0020);
        exp_push(32'h20); chk("pre_repl_top", 32'(ps_stk_top));
        exp_push(32'h55); exp_push(32'd2);
        ps_push = 1'b1; ps_pop = 1'b1; ps_push_dt = 16'h0055; cyc();
        chk("repl_top", 32'(ps_stk_top));
        chk("repl_pntr", 32'(ps_stk_pntr));
        exp_push(32'h77);
        ps_stk_wrt = 1'b1; ps_stk_wrt_dt = 16'h0077; cyc();
        chk("wrt_top", 32'(ps_stk_top));
        exp_push(32'h10); exp_push(32'd1);
        ps_stk_wrt = 1'b1; ps_stk_wrt_dt = 16'h0066; ps_pop = 1'b1; cyc();
        chk("wrt_pop_top", 32'(ps_stk_top));
        chk("wrt_pop_pntr", 32'(ps_stk_pntr));
        ps_pop = 1'b1; cyc();
        exp_push(32'h0); exp_push(32'd0);
        ps_stk_wrt = 1'b1; ps_stk_wrt_dt = 16'h0066; cyc();
        chk("wrt_empty_top", 32'(ps_stk_top));
        chk("wrt_empty_pntr", 32'(ps_stk_pntr));

        // Single loop 0x100..0x103, three passes
        exp_push(32'd1); exp_push(32'd3); exp_push(32'd0);
        lp_open(16'h0100, 16'h0103, 16'd3);
        chk("lp1_pntr", 32'(ps_lp_pntr));
        chk("lp1_cnt", 32'(ps_lp_cnt_cur));
        chk("lp1_empty", 32'(ps_stcky[4]));
        exp_push(32'd0); exp_push(32'd12); exp_push(32'd2); exp_push(32'd0);
        exp_push(32'd3); exp_push(32'd0); exp_push(32'd1);
        fetch_run(16'h0100, 16'h0104, 16'hFFFF, 16'h0, 16'h0, 16'h0,
                  16'h0100, 16'hFFFF, 16'h0103);
        chk("lp1_timeout", 32'(timed_out));
        chk("lp1_fetches", 32'(f_cnt));
        chk("lp1_jmps", 32'(j_a));
        chk("lp1_bad_jmps", 32'(j_b + j_bad));
        chk("lp1_end_fetches", 32'(w_cnt));
        chk("lp1_pntr_end", 32'(ps_lp_pntr));
        chk("lp1_empty_end", 32'(ps_stcky[4]));

        // Nested: outer 0x200..0x20A x2, inner 0x202..0x205 x2 opened at 0x201
        // each outer pass, so the inner body completes 4 times in total.
        exp_push(32'd0); exp_push(32'd30); exp_push(32'd1); exp_push(32'd2);
        exp_push(32'd0); exp_push(32'd4); exp_push(32'd0);
        lp_open(16'h0200, 16'h020A, 16'd2);
        fetch_run(16'h0200, 16'h020B, 16'h0201, 16'h0202, 16'h0205, 16'd2,
                  16'h0200, 16'h0202, 16'h0205);
        chk("nest_timeout", 32'(timed_out));
        chk("nest_fetches", 32'(f_cnt));
        chk("nest_outer_jmps", 32'(j_a));
        chk("nest_inner_jmps", 32'(j_b));
        chk("nest_bad_jmps", 32'(j_bad));
        chk("nest_inner_passes", 32'(w_cnt));
        chk("nest_pntr_end", 32'(ps_lp_pntr));

        // Loop-stack overflow, abort, abort-suppresses-jump, abort when empty
        exp_push(32'd2); exp_push(32'h61); exp_push(32'd9);
        lp_open(16'h0600, 16'h0610, 16'd7);
        lp_open(16'h0620, 16'h0630, 16'd9);
        lp_open(16'h0640, 16'h0650, 16'd4);
        chk("lpovf_pntr", 32'(ps_lp_pntr));
        chk("lpovf_stcky", 32'(ps_stcky));
        chk("lpovf_cnt", 32'(ps_lp_cnt_cur));
        exp_push(32'd1); exp_push(32'd7);
        ps_lp_abort = 1'b1; cyc();
        chk("abort_pntr", 32'(ps_lp_pntr));
        chk("abort_cnt", 32'(ps_lp_cnt_cur));
        exp_push(32'd1); exp_push(32'h600); exp_push(32'd0); exp_push(32'd0);
        ps_fetch_en = 1'b1; ps_fetch_add = 16'h0610;
        #1;
        chk("hit_jmp", 32'(ps_lp_jmp));
        chk("hit_target", 32'(ps_lp_jmp_add));
        ps_lp_abort = 1'b1;
        #1;
        chk("abort_no_jmp", 32'(ps_lp_jmp));
        cyc();
        chk("abort2_pntr", 32'(ps_lp_pntr));
        exp_push(32'hD1);
        ps_lp_abort = 1'b1; cyc();
        chk("lp_unf_stcky", 32'(ps_stcky));
        exp_push(32'h11);
        ps_stcky_clr = 1'b1; cyc();
        chk("lp_clr", 32'(ps_stcky));

        // Zero count loop: one pass, no redirect
        exp_push(32'd1);
        lp_open(16'h0300, 16'h0302, 16'd0);
        chk("cnt0_stored", 32'(ps_lp_cnt_cur));
        exp_push(32'd0); exp_push(32'd3); exp_push(32'd0); exp_push(32'd0);
        fetch_run(16'h0300, 16'h0303, 16'hFFFF, 16'h0, 16'h0, 16'h0,
                  16'h0300, 16'hFFFF, 16'h0302);
        chk("cnt0_timeout", 32'(timed_out));
        chk("cnt0_fetches", 32'(f_cnt));
        chk("cnt0_jmps", 32'(j_a + j_b + j_bad));
        chk("cnt0_pntr", 32'(ps_lp_pntr));

        // Asynchronous reset in the middle of a call and a loop
        ps_pop = 1'b1; cyc();
        pc_push(16'h1234);
        lp_open(16'h0400, 16'h0401, 16'd5);
        exp_push(32'h08);
        chk("pre_rst_stcky", 32'(ps_stcky));
        exp_push(32'd1);
        ps_fetch_en = 1'b1; ps_fetch_add = 16'h0401;
        #1;
        chk("pre_rst_jmp", 32'(ps_lp_jmp));
        exp_push(32'd0); exp_push(32'h11); exp_push(32'd0); exp_push(32'd0); exp_push(32'h0);
        #1 rst = 1'b1;
        #1;
        chk("arst_jmp", 32'(ps_lp_jmp));
        chk("arst_stcky", 32'(ps_stcky));
        chk("arst_pntr", 32'(ps_stk_pntr));
        chk("arst_lp_pntr", 32'(ps_lp_pntr));
        chk("arst_top", 32'(ps_stk_top));
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_push(32'd0);
        chk("post_rst_cnt", 32'(ps_lp_cnt_cur));

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_leftover: observed %0d queued, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
